// File: rtl/rv32i_mux_pkg.sv
// Shared types and constants for the RV32I writeback-source select path.
//   occ_e      : occupancy of the main/skid output stage
//   DEF_DATA_W : default datapath width
//   WB_*       : writeback-source select codes driven by the decoder
package rv32i_mux_pkg;

  typedef enum logic [1:0] {
    OCC_EMPTY,
    OCC_ONE,
    OCC_FULL
  } occ_e;

  localparam int unsigned DEF_DATA_W = 32;

  localparam int unsigned WB_ALU   = 0;
  localparam int unsigned WB_IMM   = 1;
  localparam int unsigned WB_PC4   = 2;
  localparam int unsigned WB_LD    = 3;
  localparam int unsigned WB_AUIPC = 4;
  localparam int unsigned N_WB_SRC = 5;

endpackage : rv32i_mux_pkg

// File: rtl/mux_nx1.sv
// Combinational N:1 select; an index at or beyond N_IN returns zero.
//   in_data    : packed inputs, input k = in_data[k*DATA_W +: DATA_W]
//   in_sel     : input index
//   sel_data_c : selected word (combinational)
module mux_nx1 #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned N_IN   = 5,
  parameter int unsigned SEL_W  = $clog2(N_IN) + 1
) (
  input  logic [N_IN*DATA_W-1:0] in_data,
  input  logic [SEL_W-1:0]       in_sel,
  output logic [DATA_W-1:0]      sel_data_c
);

  // Compare-and-pick so unmatched indices fall through to the zero default.
  always_comb begin
    sel_data_c = '0;
    for (int unsigned k = 0; k < N_IN; k++) begin
      if (in_sel == SEL_W'(k)) begin
        sel_data_c = in_data[k*DATA_W +: DATA_W];
      end
    end
  end

endmodule : mux_nx1

// File: rtl/mux_nx1_skid.sv
// N:1 datapath select feeding a two-entry (main + skid) registered output
// stage with valid/ready handshakes on both sides. in_ready depends only on
// registered occupancy. Out-of-range selects produce zero data and are
// recorded in a sticky flag and a saturating counter.
//   clk, reset           : clock, synchronous active-high reset
//   in_data/in_sel       : packed candidate words and their index
//   in_valid/in_ready    : upstream handshake (in_ready registered)
//   flush                : drop every held beat and the beat on offer
//   out_data/out_valid   : registered result and its qualifier
//   out_ready            : downstream accepts
//   sel_err/err_cnt      : sticky out-of-range flag and saturating count
//   err_clr              : clears sel_err/err_cnt (a same-cycle error wins)
module mux_nx1_skid
  import rv32i_mux_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned N_IN   = N_WB_SRC,
  parameter int unsigned SEL_W  = $clog2(N_IN) + 1,
  parameter int unsigned ERR_W  = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_IN*DATA_W-1:0] in_data,
  input  logic [SEL_W-1:0]       in_sel,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   flush,
  output logic [DATA_W-1:0]      out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   sel_err,
  output logic [ERR_W-1:0]       err_cnt,
  input  logic                   err_clr
);

  occ_e              state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic              sel_err_q, sel_err_d;
  logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;

  logic [DATA_W-1:0] sel_data_c;
  logic              accept_c;
  logic              produce_c;
  logic              bad_sel_c;

  mux_nx1 #(
    .DATA_W (DATA_W),
    .N_IN   (N_IN),
    .SEL_W  (SEL_W)
  ) u_mux (
    .in_data    (in_data),
    .in_sel     (in_sel),
    .sel_data_c (sel_data_c)
  );

  // A beat offered during flush is not accepted at all.
  assign accept_c  = in_valid && in_ready_q && !flush;
  assign produce_c = out_valid_q && out_ready;
  assign bad_sel_c = (in_sel >= SEL_W'(N_IN));

  // Occupancy next-state and data movement.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = OCC_EMPTY;
    end else begin
      unique case (state_q)
        OCC_EMPTY: begin
          if (accept_c) begin
            main_d  = sel_data_c;
            state_d = OCC_ONE;
          end
        end
        OCC_ONE: begin
          if (accept_c && produce_c) begin
            main_d = sel_data_c;
          end else if (accept_c) begin
            skid_d  = sel_data_c;
            state_d = OCC_FULL;
          end else if (produce_c) begin
            state_d = OCC_EMPTY;
          end
        end
        OCC_FULL: begin
          // in_ready is low here, so only the skid-to-main move can happen.
          if (produce_c) begin
            main_d  = skid_q;
            state_d = OCC_ONE;
          end
        end
        default: state_d = OCC_EMPTY;
      endcase
    end
    in_ready_d  = (state_d != OCC_FULL);
    out_valid_d = (state_d != OCC_EMPTY);
  end

  // Error flag/counter: an erroring accept overrides a same-cycle clear.
  always_comb begin
    sel_err_d = sel_err_q;
    err_cnt_d = err_cnt_q;
    if (accept_c && bad_sel_c) begin
      sel_err_d = 1'b1;
      if (err_clr) begin
        err_cnt_d = ERR_W'(1);
      end else if (err_cnt_q != '1) begin
        err_cnt_d = err_cnt_q + ERR_W'(1);
      end
    end else if (err_clr) begin
      sel_err_d = 1'b0;
      err_cnt_d = '0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= OCC_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      sel_err_q   <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      sel_err_q   <= sel_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;
  assign sel_err   = sel_err_q;
  assign err_cnt   = err_cnt_q;

endmodule : mux_nx1_skid
